// File: rtl/rtx_pixel_collector_pkg.sv
// Shared types for the ray-tracer pixel collector: 565 pixel layout,
// framebuffer depth helper and the collector state encoding.
package rtx_pixel_collector_pkg;

  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 720;

  function automatic int fb_depth(input int w, input int h);
    return w * h;
  endfunction

  localparam int FB_DEPTH = fb_depth(DEF_WIDTH, DEF_HEIGHT);

  typedef struct packed {
    logic [4:0] b;
    logic [5:0] g;
    logic [4:0] r;
  } rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } coll_state_t;

endpackage

// File: rtl/rtx_addr_fifo.sv
// In-order queue of framebuffer addresses for pixels in flight in the tracer.
// Head is show-ahead so the popped address is available in the pop cycle.
module rtx_addr_fifo #(
  parameter int DEPTH = 64,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when indices match.
  assign head  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/rtx_pixel_collector.sv
// Issues raster-order pixel coordinates to the tracer and writes returned
// 565 colours to the framebuffer at the address queued when each was issued.
module rtx_pixel_collector
  import rtx_pixel_collector_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int HEIGHT       = DEF_HEIGHT,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [10:0]                       pixel_h_out,
  output logic [9:0]                        pixel_v_out,
  output logic                              pixel_valid,
  input  logic                              pixel_ready,
  input  logic [15:0]                       rtx_pixel,
  input  logic                              ray_done,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   fb_addr,
  output logic [15:0]                       fb_data,
  output logic                              fb_we,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              err_unexpected
);

  localparam int              AW      = $clog2(WIDTH*HEIGHT);
  localparam int              IW      = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [10:0]     H_LAST  = 11'(WIDTH - 1);
  localparam logic [9:0]      V_LAST  = 10'(HEIGHT - 1);
  localparam logic [IW-1:0]   INF_MAX = IW'(MAX_INFLIGHT);

  coll_state_t   state_q, state_d;
  logic [10:0]   h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  rgb565_t       fb_data_q, fb_data_d;
  logic          err_q, err_d;

  logic [AW-1:0] fifo_head;
  logic          fifo_full, fifo_empty;
  logic          issue_ok, xfer, pop;

  // Throttle is a compare on registered inflight, so it drops in the full cycle.
  assign issue_ok = (state_q == ST_ISSUE) && (inflight_q < INF_MAX) && !fifo_full;
  assign xfer     = issue_ok && pixel_ready;
  assign pop      = ray_done && !fifo_empty;

  rtx_addr_fifo #(.DEPTH(MAX_INFLIGHT), .DW(AW)) u_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .pop   (pop),
    .din   (addr_q),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    addr_d     = addr_q;
    inflight_d = inflight_q + IW'(xfer) - IW'(pop);
    fb_we_d    = pop;
    fb_addr_d  = pop ? fifo_head : fb_addr_q;
    fb_data_d  = pop ? rgb565_t'(rtx_pixel) : fb_data_q;
    err_d      = err_q | (ray_done && fifo_empty);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          h_d     = '0;
          v_d     = '0;
          addr_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          if (h_q == H_LAST) begin
            h_d = '0;
            v_d = v_q + 10'd1;
          end else begin
            h_d = h_q + 11'd1;
          end
          if (h_q == H_LAST && v_q == V_LAST) state_d = ST_DRAIN;
          else                                addr_d  = addr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      h_q        <= '0;
      v_q        <= '0;
      addr_q     <= '0;
      inflight_q <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      err_q      <= err_d;
    end
  end

  assign pixel_valid    = issue_ok;
  assign pixel_h_out    = issue_ok ? h_q : 11'd0;
  assign pixel_v_out    = issue_ok ? v_q : 10'd0;
  assign fb_we          = fb_we_q;
  assign fb_addr        = fb_addr_q;
  assign fb_data        = fb_data_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_DONE);
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_rtx_pixel_collector.sv
// Bench for rtx_pixel_collector: randomized tracer/ready behaviour checked
// every cycle against a queue-based reference of the collector.
module tb_rtx_pixel_collector;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int MI = 4;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, start, pixel_ready, ray_done;
  logic [15:0]   rtx_pixel;
  logic [10:0]   pixel_h_out;
  logic [9:0]    pixel_v_out;
  logic          pixel_valid;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data;
  logic          fb_we, busy, frame_done, err_unexpected;

  always #5 clk = ~clk;

  rtx_pixel_collector #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(MI)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pixel_h_out    (pixel_h_out),
    .pixel_v_out    (pixel_v_out),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .rtx_pixel      (rtx_pixel),
    .ray_done       (ray_done),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .fb_we          (fb_we),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_unexpected (err_unexpected)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 issuing, 2 draining, 3 done pulse.
  int phase = 0;
  int idx   = 0;
  int aq[$];
  bit m_we  = 0;
  int m_addr = 0, m_data = 0;
  bit m_err = 0;
  int cyc   = 0;

  // Tracer model: in-order returns, each no earlier than its due cycle.
  int tq_addr[$];
  int tq_due[$];
  bit rdy_rand  = 0;
  bit rand_data = 0;
  int lat_lo = 5, lat_hi = 5;
  int block_until = 0;
  int hold_idx = -1, hold_left = 0;
  bit inject_rd = 0;
  int n_xfer = 0, n_wr = 0, n_fd = 0;

  task automatic step(input bit do_rst, input bit do_start);
    bit exp_valid, xfer, rd;
    int pre, a;
    @(negedge clk);
    exp_valid = (phase == 1) && (aq.size() < MI);
    check_val("pixel_valid", pixel_valid, exp_valid);
    check_val("pixel_h", pixel_h_out, exp_valid ? idx % W : 0);
    check_val("pixel_v", pixel_v_out, exp_valid ? idx / W : 0);
    check_val("fb_we", fb_we, m_we);
    if (m_we) begin
      check_val("fb_addr", fb_addr, m_addr);
      check_val("fb_data", fb_data, m_data);
      n_wr++;
    end
    check_val("busy", busy, phase != 0);
    check_val("frame_done", frame_done, phase == 3);
    check_val("err_unexpected", err_unexpected, m_err);
    check_val("inflight", dut.inflight_q, aq.size());
    if (frame_done) n_fd++;

    rst   = do_rst;
    start = do_start;
    if (exp_valid && hold_idx == idx && hold_left > 0) begin
      pixel_ready = 1'b0;
      hold_left--;
    end else begin
      pixel_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rd = 0;
    rtx_pixel = 16'($urandom);
    if (inject_rd) begin
      rd = 1;
    end else if (cyc >= block_until && tq_addr.size() > 0 && tq_due[0] <= cyc) begin
      rd = 1;
      a  = tq_addr.pop_front();
      void'(tq_due.pop_front());
      rtx_pixel = rand_data ? 16'($urandom) : 16'(16'h1000 + a);
    end
    ray_done = rd;
    xfer = exp_valid && pixel_ready;

    if (do_rst) begin
      phase = 0; idx = 0; m_we = 0; m_err = 0;
      aq.delete(); tq_addr.delete(); tq_due.delete();
    end else begin
      pre  = aq.size();
      m_we = 0;
      if (rd) begin
        if (pre == 0) m_err = 1;
        else begin
          m_we   = 1;
          m_addr = aq.pop_front();
          m_data = int'(rtx_pixel);
        end
      end
      if (xfer) begin
        aq.push_back(idx);
        tq_addr.push_back(idx);
        tq_due.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
        idx++;
        n_xfer++;
      end
      case (phase)
        0: if (do_start) begin phase = 1; idx = 0; end
        1: if (xfer && idx == N) phase = 2;
        2: if (pre == 0) phase = 3;
        default: phase = 0;
      endcase
    end
    cyc++;
  endtask

  task automatic finish_frame(input string tag, input int budget);
    int k = 0;
    while (phase != 0 && k < budget) begin
      step(0, 0);
      k++;
    end
    check_val({tag, "_timeout"}, phase, 0);
    step(0, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; pixel_ready = 1'b0; ray_done = 1'b0; rtx_pixel = '0;

    step(1, 0);
    check_val("rst_fb_addr", fb_addr, 0);
    check_val("rst_fb_data", fb_data, 0);
    step(1, 0);
    step(0, 0);

    // Fixed latency 5, always ready, data 0x1000+addr.
    n_wr = 0; n_fd = 0;
    step(0, 1);
    finish_frame("f1", 200);
    check_val("f1_writes", n_wr, N);
    check_val("f1_last_data", m_data, 16'h1007);
    check_val("f1_frame_done_cnt", n_fd, 1);

    // Tracer silent for 20 cycles: only MI transfers may happen.
    n_xfer = 0; n_wr = 0; n_fd = 0;
    block_until = cyc + 21;
    step(0, 1);
    for (int i = 0; i < 20; i++) step(0, 0);
    check_val("full_xfer_cnt", n_xfer, MI);
    check_val("full_valid_low", pixel_valid, 0);
    finish_frame("f2", 300);
    check_val("f2_writes", n_wr, N);

    // Random ready and latency, ready held low three cycles at (2,1).
    rdy_rand = 1; rand_data = 1; lat_lo = 1; lat_hi = 6;
    for (int f = 0; f < 3; f++) begin
      n_wr = 0; n_fd = 0;
      hold_idx = 6; hold_left = 3;
      step(0, 1);
      finish_frame("rnd", 600);
      check_val("rnd_writes", n_wr, N);
      check_val("rnd_frame_done_cnt", n_fd, 1);
      check_val("rnd_hold_used", hold_left, 0);
    end
    hold_idx = -1;

    // Start ignored while busy.
    n_wr = 0;
    step(0, 1);
    for (int i = 0; i < 4; i++) step(0, 1);
    finish_frame("restart_ignored", 600);
    check_val("restart_ignored_writes", n_wr, N);

    // Stray ray_done in idle sets the sticky error; rst clears it.
    inject_rd = 1;
    step(0, 0);
    inject_rd = 0;
    for (int i = 0; i < 4; i++) step(0, 0);
    check_val("err_sticky", err_unexpected, 1);
    step(1, 0);
    step(0, 0);
    check_val("err_cleared", err_unexpected, 0);

    // Reset mid-frame after 5 transfers, then a clean frame.
    rdy_rand = 0; lat_lo = 3; lat_hi = 3;
    n_xfer = 0;
    step(0, 1);
    k = 0;
    while (n_xfer < 5 && k < 50) begin
      step(0, 0);
      k++;
    end
    check_val("midrst_xfers", n_xfer, 5);
    step(1, 0);
    step(0, 0);
    check_val("midrst_inflight", dut.inflight_q, 0);
    n_wr = 0; n_fd = 0;
    step(0, 1);
    check_val("midrst_h0", pixel_h_out, 0);
    check_val("midrst_v0", pixel_v_out, 0);
    finish_frame("midrst", 300);
    check_val("midrst_writes", n_wr, N);
    check_val("final_err", err_unexpected, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
